// File: rtl/instruction_dispatch_unit_if.sv
// Bus bundle between the dispatch unit, task instruction memory and the PIM core.
// The master side is the dispatch unit; the slave side is memory plus core.
interface instruction_dispatch_unit_if #(
    parameter int INSTRUCTION_WIDTH = 64,
    parameter int INTERCORE_DEPTH   = 8192
);
    logic                         mem_read_en;
    logic [15:0]                  mem_read_addr;
    logic [INTERCORE_DEPTH-1:0]   mem_rdata;
    logic                         inst_valid;
    logic [INSTRUCTION_WIDTH-1:0] inst_data;
    logic                         inst_ready;

    modport master (
        output mem_read_en, mem_read_addr, inst_valid, inst_data,
        input  mem_rdata, inst_ready
    );

    modport slave (
        input  mem_read_en, mem_read_addr, inst_valid, inst_data,
        output mem_rdata, inst_ready
    );
endinterface

// File: rtl/instruction_dispatch_unit.sv
// Unpacks 8192-bit instruction lines into 64-bit basic instructions for the PIM core.
// S slots are skipped, W slots stall locally, every other slot goes out over valid/ready.
module instruction_dispatch_unit #(
    parameter int         INSTRUCTION_WIDTH = 64,
    parameter int         INTERCORE_DEPTH   = 8192,
    parameter logic [3:0] S                 = 4'd0,
    parameter logic [3:0] W                 = 4'd10
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        start,
    input  logic [15:0] base_addr,
    input  logic [15:0] line_count,
    output logic        busy,
    output logic        done,
    output logic [31:0] issued_count,
    instruction_dispatch_unit_if.master bus
);
    localparam int              WORDS_PER_LINE = INTERCORE_DEPTH / INSTRUCTION_WIDTH;
    localparam int              SLOT_W         = $clog2(WORDS_PER_LINE);
    localparam logic [SLOT_W-1:0] LAST_SLOT    = SLOT_W'(WORDS_PER_LINE - 1);
    localparam logic [15:0]     LINE_STEP      = 16'(WORDS_PER_LINE);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        LOAD     = 3'd2,
        ISSUE    = 3'd3,
        WAIT_CNT = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                       state_r;
    state_t                       state_next_s;
    state_t                       adv_state_s;
    logic [INTERCORE_DEPTH-1:0]   line_buf_r;
    logic [SLOT_W-1:0]            slot_r;
    logic [15:0]                  line_cnt_r;
    logic [15:0]                  line_count_r;
    logic [15:0]                  addr_r;
    logic [31:0]                  wait_cnt_r;
    logic [31:0]                  issued_count_r;
    logic                         busy_r;
    logic                         done_r;
    logic                         mem_read_en_r;
    logic [INSTRUCTION_WIDTH-1:0] cur_s;
    logic [3:0]                   op_s;
    logic                         last_line_s;
    logic                         advance_s;
    logic                         accept_s;
    logic                         inst_valid_s;

    assign cur_s       = line_buf_r[int'(slot_r) * INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
    assign op_s        = cur_s[INSTRUCTION_WIDTH-1 -: 4];
    assign last_line_s = ((line_cnt_r + 16'd1) == line_count_r);
    // Leaving the last slot either finishes the run or fetches the next line.
    assign adv_state_s = (slot_r == LAST_SLOT) ? (last_line_s ? DONE : FETCH) : ISSUE;

    assign bus.mem_read_en   = mem_read_en_r;
    assign bus.mem_read_addr = addr_r;
    assign bus.inst_valid    = inst_valid_s;
    assign bus.inst_data     = inst_valid_s ? cur_s : {INSTRUCTION_WIDTH{1'b0}};
    assign busy              = busy_r;
    assign done              = done_r;
    assign issued_count      = issued_count_r;

    // State register
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and per-slot present/advance decisions
    always_comb begin
        state_next_s = state_r;
        inst_valid_s = 1'b0;
        accept_s     = 1'b0;
        advance_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (line_count == 16'd0) ? DONE : FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: state_next_s = LOAD;
            LOAD:  state_next_s = ISSUE;
            ISSUE: begin
                if (op_s == S) begin
                    advance_s    = 1'b1;
                    state_next_s = adv_state_s;
                end else if (op_s == W) begin
                    if (cur_s[31:0] == 32'd0) begin
                        advance_s    = 1'b1;
                        state_next_s = adv_state_s;
                    end else begin
                        state_next_s = WAIT_CNT;
                    end
                end else begin
                    inst_valid_s = 1'b1;
                    accept_s     = bus.inst_ready;
                    advance_s    = bus.inst_ready;
                    state_next_s = bus.inst_ready ? adv_state_s : ISSUE;
                end
            end
            WAIT_CNT: begin
                if (wait_cnt_r <= 32'd1) begin
                    advance_s    = 1'b1;
                    state_next_s = adv_state_s;
                end else begin
                    state_next_s = WAIT_CNT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Status and memory strobe registered from the next state
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            mem_read_en_r <= 1'b0;
        end else begin
            busy_r        <= (state_next_s != IDLE);
            done_r        <= (state_next_s == DONE);
            mem_read_en_r <= (state_next_s == FETCH);
        end
    end

    // Run bookkeeping: line/slot position, addresses, wait counter, issue count
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            line_buf_r     <= {INTERCORE_DEPTH{1'b0}};
            slot_r         <= {SLOT_W{1'b0}};
            line_cnt_r     <= 16'd0;
            line_count_r   <= 16'd0;
            addr_r         <= 16'd0;
            wait_cnt_r     <= 32'd0;
            issued_count_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        addr_r         <= base_addr;
                        line_count_r   <= line_count;
                        line_cnt_r     <= 16'd0;
                        slot_r         <= {SLOT_W{1'b0}};
                        issued_count_r <= 32'd0;
                    end
                end
                LOAD: begin
                    line_buf_r <= bus.mem_rdata;
                    slot_r     <= {SLOT_W{1'b0}};
                end
                ISSUE: begin
                    if (op_s == W) begin
                        wait_cnt_r <= cur_s[31:0];
                    end
                end
                WAIT_CNT: wait_cnt_r <= wait_cnt_r - 32'd1;
                default: ;
            endcase
            if (accept_s) begin
                issued_count_r <= issued_count_r + 32'd1;
            end
            if (advance_s) begin
                if (slot_r == LAST_SLOT) begin
                    slot_r <= {SLOT_W{1'b0}};
                    if (!last_line_s) begin
                        line_cnt_r <= line_cnt_r + 16'd1;
                        addr_r     <= addr_r + LINE_STEP;
                    end
                end else begin
                    slot_r <= slot_r + {{(SLOT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end
endmodule
